uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/flex_counter.sv | 32 +++
 rtl/uart_tx.sv | 129 ++++++++++++
 tb/tb_uart_tx.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared serial-link types and line levels
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - enable/clear counter that wraps rollover_val -> 1
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count;

    // Counts 1..rollover_val; 0 only after clear, so the first enable lands on 1.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count <= NUM_CNT_BITS'(1);
            end else begin
                count <= count + NUM_CNT_BITS'(1);
            end
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter with registered line output
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_out
);

    // One extra bit so a power-of-two CLKS_PER_BIT still fits the 1..N count.
    localparam int PW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);

    tx_state_t            state, state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_down;
    logic                 period_roll, bit_roll;
    logic                 period_en, period_clear;
    logic                 bit_en, bit_clear;
    logic                 load, shift;
    logic                 serial_next, busy_next, done_next;

    assign shift_down = shift_reg >> 1;

    flex_counter #(.NUM_CNT_BITS(PW)) u_period (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (period_clear),
        .count_enable  (period_en),
        .rollover_val  (PW'(CLKS_PER_BIT)),
        .rollover_flag (period_roll)
    );

    flex_counter #(.NUM_CNT_BITS(BW)) u_bits (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (bit_clear),
        .count_enable  (bit_en),
        .rollover_val  (BW'(DATA_BITS)),
        .rollover_flag (bit_roll)
    );

    always_comb begin
        state_next   = state;
        serial_next  = LINE_IDLE;
        done_next    = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        period_en    = 1'b1;
        period_clear = 1'b0;
        bit_en       = 1'b0;
        bit_clear    = 1'b0;
        case (state)
            IDLE: begin
                bit_clear = 1'b1;
                if (tx_start) begin
                    state_next  = START;
                    load        = 1'b1;
                    serial_next = START_LEVEL;
                end else begin
                    period_en    = 1'b0;
                    period_clear = 1'b1;
                end
            end
            START: begin
                // Bit counter moves to 1 here so it tracks the data bit on the line.
                serial_next = START_LEVEL;
                bit_en      = period_roll;
                if (period_roll) begin
                    state_next  = DATA;
                    serial_next = shift_reg[0];
                end
            end
            DATA: begin
                serial_next = shift_reg[0];
                bit_en      = period_roll;
                if (period_roll) begin
                    shift = 1'b1;
                    if (bit_roll) begin
                        state_next  = STOP;
                        serial_next = STOP_LEVEL;
                    end else begin
                        serial_next = shift_down[0];
                    end
                end
            end
            STOP: begin
                serial_next = STOP_LEVEL;
                bit_clear   = 1'b1;
                if (period_roll) begin
                    state_next   = IDLE;
                    period_clear = 1'b1;
                    done_next    = 1'b1;
                    serial_next  = LINE_IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            serial_out <= LINE_IDLE;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state      <= state_next;
            serial_out <= serial_next;
            tx_busy    <= busy_next;
            tx_done    <= done_next;
            if (load) begin
                shift_reg <= tx_data;
            end else if (shift) begin
                shift_reg <= shift_down;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_data, tx_data2;
    logic       tx_start, tx_start2;
    logic       tx_busy, tx_done, serial_out;
    logic       tx_busy2, tx_done2, serial_out2;

    int total = 0;
    int bad   = 0;

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(10)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .serial_out (serial_out)
    );

    uart_tx #(.DATA_BITS(8), .CLKS_PER_BIT(2)) dut2 (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_data    (tx_data2),
        .tx_start   (tx_start2),
        .tx_busy    (tx_busy2),
        .tx_done    (tx_done2),
        .serial_out (serial_out2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Called just after the accepting edge; returns in the tx_done cycle.
    task automatic frame(input string tag, input logic [0:9] bits,
                         input int poke_a, input int poke_b, input int abort_at);
        for (int c = 0; c < 100; c++) begin
            chk({tag, ".line"}, c, serial_out, bits[c / 10]);
            chk({tag, ".busy"}, c, tx_busy, 1'b1);
            chk({tag, ".done"}, c, tx_done, 1'b0);
            tx_start = (c + 1 == poke_a) || (c + 1 == poke_b);
            if (c + 1 == poke_a) tx_data = 8'hC3;
            if (c + 1 == abort_at) begin
                n_rst = 1'b0;
                tick();
                chk({tag, ".abort_line"}, c + 1, serial_out, 1'b1);
                chk({tag, ".abort_busy"}, c + 1, tx_busy, 1'b0);
                chk({tag, ".abort_done"}, c + 1, tx_done, 1'b0);
                n_rst = 1'b1;
                return;
            end
            tick();
        end
        tx_start = 1'b0;
        chk({tag, ".end_done"}, 100, tx_done, 1'b1);
        chk({tag, ".end_busy"}, 100, tx_busy, 1'b0);
        chk({tag, ".end_line"}, 100, serial_out, 1'b1);
    endtask

    task automatic idle_for(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            chk({tag, ".line"}, c, serial_out, 1'b1);
            chk({tag, ".busy"}, c, tx_busy, 1'b0);
            chk({tag, ".done"}, c, tx_done, 1'b0);
        end
    endtask

    initial begin
        n_rst     = 1'b0;
        tx_start  = 1'b1;
        tx_data   = 8'h5A;
        tx_start2 = 1'b1;
        tx_data2  = 8'h00;

        // Reset held three edges with a start request pending
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst.line", c, serial_out, 1'b1);
            chk("rst.busy", c, tx_busy, 1'b0);
            chk("rst.done", c, tx_done, 1'b0);
            chk("rst2.line", c, serial_out2, 1'b1);
        end
        tx_start  = 1'b0;
        tx_start2 = 1'b0;
        n_rst     = 1'b1;
        idle_for("post_rst", 3);

        // Single frame 0xA5
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick();
        frame("a5", 10'b0101001011, -1, -1, -1);
        idle_for("a5_idle", 2);

        // Back-to-back: 0x00, then 0xFF requested in the done cycle
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick();
        frame("b2b0", 10'b0000000001, -1, -1, -1);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        tick();
        frame("b2b1", 10'b0111111111, -1, -1, -1);
        idle_for("b2b_idle", 2);

        // Starts during a frame are ignored and new data has no effect
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        tick();
        frame("ign", 10'b0001111001, 30, 55, -1);
        idle_for("ign_idle", 30);

        // Reset at cycle 45, then a clean frame
        tx_data  = 8'hA5;
        tx_start = 1'b1;
        tick();
        frame("abort", 10'b0101001011, -1, -1, 45);
        idle_for("abort_idle", 110);
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        tick();
        frame("after", 10'b0001111001, -1, -1, -1);
        idle_for("after_idle", 2);

        // CLKS_PER_BIT=2 instance, 0x81
        begin
            logic [0:9] b81;
            b81       = 10'b0100000011;
            tx_data2  = 8'h81;
            tx_start2 = 1'b1;
            tick();
            tx_start2 = 1'b0;
            for (int c = 0; c < 20; c++) begin
                chk("p2.line", c, serial_out2, b81[c / 2]);
                chk("p2.busy", c, tx_busy2, 1'b1);
                chk("p2.done", c, tx_done2, 1'b0);
                tick();
            end
            chk("p2.end_done", 20, tx_done2, 1'b1);
            chk("p2.end_busy", 20, tx_busy2, 1'b0);
            tick();
            chk("p2.idle_done", 21, tx_done2, 1'b0);
            chk("p2.idle_line", 21, serial_out2, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
